rvsteel_spi_sequencer: RTL and testbench

RVSTEEL_SPI_SEQUENCER -- requirements
Module: rvsteel_spi_sequencer

---
 rtl/rvsteel_spi_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_rvsteel_spi_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvsteel_spi_sequencer.sv
// rtl/rvsteel_spi_sequencer.sv - two-requester byte sequencer driving a memory-mapped SPI master (optional poll timeout: SPI_SEQ_TIMEOUT_EN)
module rvsteel_spi_sequencer #(
  parameter logic [15:0] CS_MAP        = 16'h0100,
  parameter logic [3:0]  MODE_MAP      = 4'b0000,
  parameter logic [15:0] DIV_MAP       = 16'h0404,
  parameter int          TIMEOUT_POLLS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        timeout,
  output logic [4:0]  spi_rw_address,
  output logic        spi_read_request,
  input  logic [31:0] spi_read_data,
  input  logic        spi_read_response,
  output logic [7:0]  spi_write_data,
  output logic [3:0]  spi_write_strobe,
  output logic        spi_write_request,
  input  logic        spi_write_response
);

  localparam logic [4:0] ADDR_CPOL   = 5'h00;
  localparam logic [4:0] ADDR_CPHA   = 5'h04;
  localparam logic [4:0] ADDR_CS     = 5'h08;
  localparam logic [4:0] ADDR_DIV    = 5'h0C;
  localparam logic [4:0] ADDR_WDATA  = 5'h10;
  localparam logic [4:0] ADDR_RDATA  = 5'h14;
  localparam logic [4:0] ADDR_STATUS = 5'h18;

  typedef enum logic [3:0] {
    IDLE, CFG_CPOL, CFG_CPHA, CFG_DIV, CFG_CS, WAIT_BYTE,
    WR_DATA, SETTLE, POLL, RD_DATA, DESELECT
  } state_t;

  state_t     state, state_n;
  logic       pend, pend_n;              // a bus request is outstanding
  logic       grant, grant_n;            // requester currently owning the SPI
  logic       last_grant, last_grant_n;  // requester served by the previous transaction
  logic       last_flag, last_flag_n;    // current byte closes the transaction
  logic       settle_cnt, settle_n;
  logic [4:0] addr_n;
  logic [7:0] wdata_n;
  logic       wr_req_n, rd_req_n;
  logic [1:0] ready_n, rsp_valid_n;
  logic [7:0] rsp_data_n;

  logic       cpol_g, cpha_g, valid_g, last_g, busy;
  logic [7:0] div_g, cs_g, byte_g;
  logic       unused_bits;

  // Per-requester view of the configuration maps and request inputs
  assign cpol_g  = grant ? MODE_MAP[3] : MODE_MAP[1];
  assign cpha_g  = grant ? MODE_MAP[2] : MODE_MAP[0];
  assign div_g   = grant ? DIV_MAP[15:8] : DIV_MAP[7:0];
  assign cs_g    = grant ? CS_MAP[15:8]  : CS_MAP[7:0];
  assign byte_g  = grant ? req_data[15:8] : req_data[7:0];
  assign valid_g = grant ? req_valid[1] : req_valid[0];
  assign last_g  = grant ? req_last[1]  : req_last[0];
  assign busy    = spi_read_data[0];

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int POLL_W = (TIMEOUT_POLLS > 1) ? $clog2(TIMEOUT_POLLS) : 1;
  logic [POLL_W-1:0] poll_cnt, poll_cnt_n;
  logic              timeout_n;
  assign unused_bits = ^spi_read_data[31:8];
`else
  assign unused_bits = ^{spi_read_data[31:8], (TIMEOUT_POLLS > 0)};
  assign timeout     = 1'b0;
`endif

  // Next-state and next-output decode; each register access is issued once and then waits for its response
  always_comb begin
    state_n      = state;
    pend_n       = pend;
    grant_n      = grant;
    last_grant_n = last_grant;
    last_flag_n  = last_flag;
    settle_n     = settle_cnt;
    addr_n       = spi_rw_address;
    wdata_n      = spi_write_data;
    wr_req_n     = 1'b0;
    rd_req_n     = 1'b0;
    ready_n      = 2'b00;
    rsp_valid_n  = 2'b00;
    rsp_data_n   = 8'h00;
`ifdef SPI_SEQ_TIMEOUT_EN
    poll_cnt_n   = poll_cnt;
    timeout_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_n = (&req_valid) ? ~last_grant : req_valid[1];
          state_n = CFG_CPOL;
        end
      end
      CFG_CPOL: begin
        if (!pend) begin
          wr_req_n = 1'b1; pend_n = 1'b1; addr_n = ADDR_CPOL; wdata_n = {7'd0, cpol_g};
        end else if (spi_write_response) begin
          pend_n = 1'b0; state_n = CFG_CPHA;
        end
      end
      CFG_CPHA: begin
        if (!pend) begin
          wr_req_n = 1'b1; pend_n = 1'b1; addr_n = ADDR_CPHA; wdata_n = {7'd0, cpha_g};
        end else if (spi_write_response) begin
          pend_n = 1'b0; state_n = CFG_DIV;
        end
      end
      CFG_DIV: begin
        if (!pend) begin
          wr_req_n = 1'b1; pend_n = 1'b1; addr_n = ADDR_DIV; wdata_n = div_g;
        end else if (spi_write_response) begin
          pend_n = 1'b0; state_n = CFG_CS;
        end
      end
      CFG_CS: begin
        if (!pend) begin
          wr_req_n = 1'b1; pend_n = 1'b1; addr_n = ADDR_CS; wdata_n = cs_g;
        end else if (spi_write_response) begin
          pend_n = 1'b0; state_n = WAIT_BYTE;
        end
      end
      WAIT_BYTE: begin
        if (valid_g) state_n = WR_DATA;
      end
      WR_DATA: begin
        if (!pend) begin
          wr_req_n    = 1'b1; pend_n = 1'b1; addr_n = ADDR_WDATA; wdata_n = byte_g;
          ready_n     = grant ? 2'b10 : 2'b01;
          last_flag_n = last_g;
        end else if (spi_write_response) begin
          pend_n = 1'b0; settle_n = 1'b0; state_n = SETTLE;
        end
      end
      SETTLE: begin
        // Two quiet cycles let the peripheral raise busy before the first STATUS read
        if (settle_cnt) begin
          rd_req_n = 1'b1; pend_n = 1'b1; addr_n = ADDR_STATUS; state_n = POLL;
`ifdef SPI_SEQ_TIMEOUT_EN
          poll_cnt_n = '0;
`endif
        end else begin
          settle_n = 1'b1;
        end
      end
      POLL: begin
        if (pend && spi_read_response) begin
          if (!busy) begin
            pend_n = 1'b0; state_n = RD_DATA;
          end else begin
`ifdef SPI_SEQ_TIMEOUT_EN
            if (poll_cnt == POLL_W'(TIMEOUT_POLLS - 1)) begin
              pend_n = 1'b0; timeout_n = 1'b1; state_n = DESELECT;
            end else begin
              poll_cnt_n = poll_cnt + 1'b1;
              rd_req_n   = 1'b1;
            end
`else
            rd_req_n = 1'b1;
`endif
          end
        end
      end
      RD_DATA: begin
        if (!pend) begin
          rd_req_n = 1'b1; pend_n = 1'b1; addr_n = ADDR_RDATA;
        end else if (spi_read_response) begin
          pend_n      = 1'b0;
          rsp_valid_n = grant ? 2'b10 : 2'b01;
          rsp_data_n  = spi_read_data[7:0];
          state_n     = last_flag ? DESELECT : WAIT_BYTE;
        end
      end
      DESELECT: begin
        if (!pend) begin
          wr_req_n = 1'b1; pend_n = 1'b1; addr_n = ADDR_CS; wdata_n = 8'hFF;
        end else if (spi_write_response) begin
          pend_n = 1'b0; last_grant_n = grant; state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, bookkeeping and registered bus/handshake outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      pend              <= 1'b0;
      grant             <= 1'b0;
      last_grant        <= 1'b1;
      last_flag         <= 1'b0;
      settle_cnt        <= 1'b0;
      spi_rw_address    <= 5'd0;
      spi_write_data    <= 8'd0;
      spi_write_strobe  <= 4'h0;
      spi_write_request <= 1'b0;
      spi_read_request  <= 1'b0;
      req_ready         <= 2'b00;
      rsp_valid         <= 2'b00;
      rsp_data          <= 8'd0;
    end else begin
      state             <= state_n;
      pend              <= pend_n;
      grant             <= grant_n;
      last_grant        <= last_grant_n;
      last_flag         <= last_flag_n;
      settle_cnt        <= settle_n;
      spi_rw_address    <= addr_n;
      spi_write_data    <= wdata_n;
      spi_write_strobe  <= wr_req_n ? 4'hF : 4'h0;
      spi_write_request <= wr_req_n;
      spi_read_request  <= rd_req_n;
      req_ready         <= ready_n;
      rsp_valid         <= rsp_valid_n;
      rsp_data          <= rsp_data_n;
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  // Per-byte STATUS poll counter and timeout pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      poll_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      poll_cnt <= poll_cnt_n;
      timeout  <= timeout_n;
    end
  end
`endif

endmodule

// File: tb/tb_rvsteel_spi_sequencer.sv
// tb/tb_rvsteel_spi_sequencer.sv - directed self-checking bench for rvsteel_spi_sequencer
module tb_rvsteel_spi_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [15:0] req_data = 16'h0000;
  logic [1:0]  req_last = 2'b00;
  logic [1:0]  req_ready, rsp_valid;
  logic [7:0]  rsp_data;
  logic        timeout;
  logic [4:0]  spi_rw_address;
  logic        spi_read_request, spi_write_request;
  logic [31:0] spi_read_data = 32'd0;
  logic        spi_read_response = 1'b0, spi_write_response = 1'b0;
  logic [7:0]  spi_write_data;
  logic [3:0]  spi_write_strobe;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  rvsteel_spi_sequencer #(
    .CS_MAP(16'h0100), .MODE_MAP(4'b1100), .DIV_MAP(16'h1004), .TIMEOUT_POLLS(4)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .timeout(timeout),
    .spi_rw_address(spi_rw_address),
    .spi_read_request(spi_read_request), .spi_read_data(spi_read_data), .spi_read_response(spi_read_response),
    .spi_write_data(spi_write_data), .spi_write_strobe(spi_write_strobe),
    .spi_write_request(spi_write_request), .spi_write_response(spi_write_response)
  );

  // Peripheral model knobs (written only by the stimulus process)
  int         busy_n = 0;
  logic       stuck = 1'b0;
  logic [7:0] rd_xor = 8'h00;
  int         clr_req = 0;

  // Logs (written only by the model process)
  logic [4:0] wa_q[$];
  logic [7:0] wd_q[$];
  logic [7:0] rsp_q[$];
  int         ready_order[$];
  int cyc = 0, clr_seen = 0, byte_polls = 0, status_reads = 0, desel_cnt = 0;
  int ready0_cnt = 0, rsp0_cnt = 0, rsp1_cnt = 0, timeout_cnt = 0, strobe_err = 0;
  int wdata_cyc = 0, first_status_cyc = 0;
  logic [7:0]  last_wdata = 8'h00;
  logic [31:0] rd_next = 32'd0;
  logic        wr_pend = 1'b0, rd_pend = 1'b0;

  // SPI register-file model with one-cycle response latency, plus output monitor
  always @(negedge clock) begin
    cyc++;
    if (clr_req != clr_seen) begin
      clr_seen = clr_req;
      wa_q.delete(); wd_q.delete(); rsp_q.delete(); ready_order.delete();
      status_reads = 0; desel_cnt = 0; ready0_cnt = 0; rsp0_cnt = 0; rsp1_cnt = 0;
      timeout_cnt = 0; strobe_err = 0;
    end
    if (!reset) begin
      wr_pend = 1'b0; rd_pend = 1'b0;
      spi_write_response = 1'b0; spi_read_response = 1'b0;
    end else begin
      spi_write_response = wr_pend;
      spi_read_response  = rd_pend;
      spi_read_data      = rd_next;
      wr_pend = spi_write_request;
      rd_pend = spi_read_request;
      if (spi_write_request) begin
        wa_q.push_back(spi_rw_address);
        wd_q.push_back(spi_write_data);
        if (spi_write_strobe != 4'hF) strobe_err++;
        if (spi_rw_address == 5'h10) begin
          last_wdata = spi_write_data; byte_polls = 0; wdata_cyc = cyc;
        end
        if (spi_rw_address == 5'h08 && spi_write_data == 8'hFF) desel_cnt++;
      end else if (spi_write_strobe != 4'h0) begin
        strobe_err++;
      end
      if (spi_read_request) begin
        if (spi_rw_address == 5'h18) begin
          if (byte_polls == 0) first_status_cyc = cyc;
          rd_next = {31'd0, (stuck || byte_polls < busy_n)};
          byte_polls++;
          status_reads++;
        end else begin
          rd_next = {24'd0, last_wdata ^ rd_xor};
        end
      end
      if (req_ready[0]) begin ready0_cnt++; ready_order.push_back(0); end
      if (req_ready[1]) ready_order.push_back(1);
      if (rsp_valid != 2'b00) rsp_q.push_back(rsp_data);
      if (rsp_valid[0]) rsp0_cnt++;
      if (rsp_valid[1]) rsp1_cnt++;
      if (timeout) timeout_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wa_at(input int i);
    return (i < wa_q.size()) ? {27'd0, wa_q[i]} : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] wd_at(input int i);
    return (i < wd_q.size()) ? {24'd0, wd_q[i]} : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] rsp_at(input int i);
    return (i < rsp_q.size()) ? {24'd0, rsp_q[i]} : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] order_at(input int i);
    return (i < ready_order.size()) ? ready_order[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(negedge clock); #1;
  endtask

  task automatic clear_logs();
    clr_req++;
    tick();
  endtask

  task automatic send_byte(input int k, input logic [7:0] d, input logic l);
    logic seen;
    seen = 1'b0;
    req_data[8*k +: 8] = d;
    req_last[k]  = l;
    req_valid[k] = 1'b1;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (req_ready[k]) seen = 1'b1;
    end
    check($sformatf("ready_req%0d_byte%0h", k, d), {31'd0, seen}, 32'd1);
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_desel(input int n);
    for (int i = 0; i < 3000 && desel_cnt < n; i++) tick();
    check("deselect_reached", {31'd0, desel_cnt >= n}, 32'd1);
  endtask

  task automatic check_writes(input string tag, input int n, input logic [4:0] ea[8], input logic [7:0] ed[8]);
    check({tag, "_wcount"}, wa_q.size(), n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), wa_at(i), {27'd0, ea[i]});
      check($sformatf("%s_data%0d", tag, i), wd_at(i), {24'd0, ed[i]});
    end
  endtask

  task automatic serve_both();
    req_data  = 16'h6655;
    req_last  = 2'b11;
    req_valid = 2'b11;
    for (int i = 0; i < 4000 && desel_cnt < 2; i++) begin
      tick();
      if (req_ready[0]) req_valid[0] = 1'b0;
      if (req_ready[1]) req_valid[1] = 1'b0;
    end
    check("both_two_deselects", desel_cnt, 2);
    repeat (4) tick();
  endtask

  logic [4:0] ea[8];
  logic [7:0] ed[8];

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_requests", {30'd0, spi_read_request, spi_write_request}, 32'd0);
    check("rst_address", spi_rw_address, 32'd0);
    check("rst_ready_rsp", {28'd0, req_ready, rsp_valid}, 32'd0);
    check("rst_strobe_timeout", {27'd0, spi_write_strobe, timeout}, 32'd0);
    reset = 1'b1;
    tick();

    // Single byte from requester 0, busy for three STATUS reads
    busy_n = 3; stuck = 1'b0; rd_xor = 8'h99;
    clear_logs();
    send_byte(0, 8'hA5, 1'b1);
    wait_desel(1);
    repeat (4) tick();
    ea = '{5'h00, 5'h04, 5'h0C, 5'h08, 5'h10, 5'h08, 5'h00, 5'h00};
    ed = '{8'h00, 8'h00, 8'h04, 8'h00, 8'hA5, 8'hFF, 8'h00, 8'h00};
    check_writes("single", 6, ea, ed);
    check("single_status_reads", status_reads, 4);
    check("single_rsp_count0", rsp0_cnt, 1);
    check("single_rsp_count1", rsp1_cnt, 0);
    check("single_rsp_data", rsp_at(0), 32'h3C);
    check("single_settle_gap", first_status_cyc - wdata_cyc, 4);
    check("single_strobe", strobe_err, 0);

    // Arbitration: simultaneous requests after reset, then again
    reset = 1'b0; tick(); reset = 1'b1; tick();
    busy_n = 0; rd_xor = 8'h00;
    clear_logs();
    serve_both();
    check("arb1_first", order_at(0), 0);
    check("arb1_second", order_at(1), 1);
    check("arb1_rsp0", rsp_at(0), 32'h55);
    check("arb1_rsp1", rsp_at(1), 32'h66);
    clear_logs();
    serve_both();
    check("arb2_first", order_at(0), 0);
    check("arb2_second", order_at(1), 1);

    // Multi-byte transaction from requester 1 while requester 0 waits
    busy_n = 1; rd_xor = 8'hFF;
    clear_logs();
    req_data[15:8] = 8'h11; req_last[1] = 1'b0; req_valid[1] = 1'b1;
    tick(); tick();
    req_data[7:0] = 8'h77; req_last[0] = 1'b1; req_valid[0] = 1'b1;
    send_byte(1, 8'h11, 1'b0);
    send_byte(1, 8'h22, 1'b0);
    send_byte(1, 8'h33, 1'b1);
    wait_desel(1);
    check("multi_req0_no_ready", ready0_cnt, 0);
    req_valid[0] = 1'b0;
    repeat (4) tick();
    ea = '{5'h00, 5'h04, 5'h0C, 5'h08, 5'h10, 5'h10, 5'h10, 5'h08};
    ed = '{8'h01, 8'h01, 8'h10, 8'h01, 8'h11, 8'h22, 8'h33, 8'hFF};
    check_writes("multi", 8, ea, ed);
    check("multi_rsp1_count", rsp1_cnt, 3);
    check("multi_rsp_a", rsp_at(0), 32'hEE);
    check("multi_rsp_b", rsp_at(1), 32'hDD);
    check("multi_rsp_c", rsp_at(2), 32'hCC);
    check("multi_deselects", desel_cnt, 1);

    // Reset during POLL abandons the transaction
    busy_n = 0; stuck = 1'b1; rd_xor = 8'h00;
    clear_logs();
    send_byte(0, 8'h42, 1'b1);
    for (int i = 0; i < 200 && status_reads < 2; i++) tick();
    check("poll_reached", {31'd0, status_reads >= 2}, 32'd1);
    check("poll_address", spi_rw_address, 32'h18);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    check("rst_mid_address", spi_rw_address, 32'd0);
    check("rst_mid_requests", {30'd0, spi_read_request, spi_write_request}, 32'd0);
    check("rst_mid_handshake", {24'd0, req_ready, rsp_valid, spi_write_strobe}, 32'd0);
    tick();
    reset = 1'b1; stuck = 1'b0;
    clear_logs();
    send_byte(0, 8'h42, 1'b1);
    wait_desel(1);
    repeat (4) tick();
    check("restart_first_addr", wa_at(0), 32'h00);
    check("restart_wcount", wa_q.size(), 6);
    check("restart_rsp", rsp_at(0), 32'h42);

    // Busy stuck high
    stuck = 1'b1;
    clear_logs();
    send_byte(0, 8'h5A, 1'b1);
`ifdef SPI_SEQ_TIMEOUT_EN
    wait_desel(1);
    repeat (4) tick();
    check("to_status_reads", status_reads, 4);
    check("to_pulse", timeout_cnt, 1);
    check("to_no_rsp", rsp0_cnt, 0);
    check("to_last_addr", wa_at(wa_q.size() - 1), 32'h08);
    check("to_last_data", wd_at(wd_q.size() - 1), 32'hFF);
`else
    repeat (60) tick();
    check("stuck_no_timeout", timeout_cnt, 0);
    check("stuck_keeps_polling", {31'd0, status_reads > 4}, 32'd1);
    check("stuck_no_deselect", desel_cnt, 0);
    stuck = 1'b0;
    wait_desel(1);
    repeat (4) tick();
    check("stuck_release_rsp", rsp0_cnt, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
